// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: access descriptor, read data word and FSM states.
// Optional build macro SDRAM_PORT_ARB_PRIO0_EN (strict priority for port 0) is consumed by the top.
package sdram_port_arbiter_pkg;

    localparam int ARB_N_PORTS_DEF = 4;
    localparam int ARB_BURST_DEF   = 8;

    typedef logic [15:0] data_t;

    // Column low bits carry the beat index within a burst.
    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        data_t       data;
    } dram_access_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM port arbiter.
// slave = arbiter view, master = surrounding requesters plus controller.
interface sdram_port_arbiter_if
    import sdram_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = ARB_N_PORTS_DEF
) ();

    logic [N_PORTS-1:0] REQ_IN;
    logic [N_PORTS-1:0] WRITE_IN;
    dram_access_t       ACS_IN   [N_PORTS];
    logic [N_PORTS-1:0] ACK_OUT;
    data_t              DATA_OUT [N_PORTS];
    logic [N_PORTS-1:0] GRANT_OUT;

    logic               REQ_OUT;
    logic               WRITE_OUT;
    dram_access_t       ACS_OUT;
    logic               ACK_IN;
    data_t              DATA_IN;

    modport slave (
        input  REQ_IN, WRITE_IN, ACS_IN, ACK_IN, DATA_IN,
        output ACK_OUT, DATA_OUT, GRANT_OUT, REQ_OUT, WRITE_OUT, ACS_OUT
    );

    modport master (
        output REQ_IN, WRITE_IN, ACS_IN, ACK_IN, DATA_IN,
        input  ACK_OUT, DATA_OUT, GRANT_OUT, REQ_OUT, WRITE_OUT, ACS_OUT
    );

endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational cyclic first-one finder: first set bit of req_i at or after ptr_i, wrapping.
// Returns the winner as one-hot and as an index, plus an any-request flag.
module sdram_rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [N_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int               k;
        logic [IDX_W-1:0] k_idx;
        logic             found;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        k     = 0;
        k_idx = '0;
        found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            k     = (int'(ptr_i) + i) % N_PORTS;
            k_idx = IDX_W'(k);
            if (!found && req_i[k_idx]) begin
                found        = 1'b1;
                gnt_o[k_idx] = 1'b1;
                idx_o        = k_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter granting whole BURST-beat transactions on one SDRAM controller port.
// Build macro SDRAM_PORT_ARB_PRIO0_EN: port 0 wins every IDLE pick and never moves the pointer.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = ARB_N_PORTS_DEF,
    parameter int BURST   = ARB_BURST_DEF
) (
    input  logic                CLK,
    input  logic                RESET_IN,
    sdram_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PORTS - 1);

    typedef logic [IDX_W-1:0] port_idx_t;

    arb_state_e         state_q, state_d;
    port_idx_t          idx_q, idx_d;
    port_idx_t          rr_q, rr_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_PORTS-1:0] rr_oh;
    port_idx_t          rr_idx;
    logic               rr_any;
    logic [N_PORTS-1:0] win_oh;
    port_idx_t          win_idx;
    port_idx_t          rr_after;
    logic               owner_req;

    sdram_rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (bus.REQ_IN),
        .ptr_i (rr_q),
        .gnt_o (rr_oh),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    always_comb begin
        win_oh  = rr_oh;
        win_idx = rr_idx;
`ifdef SDRAM_PORT_ARB_PRIO0_EN
        if (bus.REQ_IN[0]) begin
            win_oh    = '0;
            win_oh[0] = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    // Pointer position after the current owner releases the port.
    always_comb begin
        rr_after = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`ifdef SDRAM_PORT_ARB_PRIO0_EN
        if (idx_q == '0) begin
            rr_after = rr_q;
        end
`else
`endif
    end

    assign owner_req = bus.REQ_IN[idx_q];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        bus.REQ_OUT   = 1'b0;
        bus.WRITE_OUT = 1'b0;
        bus.ACS_OUT   = '0;
        bus.ACK_OUT   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (rr_any) begin
                    state_d = ARB_GRANT;
                    idx_d   = win_idx;
                    grant_d = win_oh;
                    cnt_d   = '0;
                end
            end

            ARB_GRANT: begin
                bus.REQ_OUT   = owner_req;
                bus.WRITE_OUT = bus.WRITE_IN[idx_q];
                bus.ACS_OUT   = bus.ACS_IN[idx_q];
                if (!owner_req) begin
                    // Owner withdrew early: release, and a late ACK_IN is not forwarded.
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    rr_d    = rr_after;
                end else if (bus.ACK_IN) begin
                    bus.ACK_OUT[idx_q] = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        rr_d    = rr_after;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q <= ARB_IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.GRANT_OUT = grant_q;

    // Read data is broadcast; only the owner sees a matching ACK_OUT.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            bus.DATA_OUT[i] = bus.DATA_IN;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (default build, pure round-robin, 4 ports, 8-beat bursts).
// Inputs change 2 time units after each rising edge; outputs are compared 1 unit later.
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int BL = 8;

    typedef logic [1:0] port_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    port_t ord_fair [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    port_t ord_pair [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};

    sdram_port_arbiter_if #(.N_PORTS(NP)) bus ();

    sdram_port_arbiter #(
        .N_PORTS (NP),
        .BURST   (BL)
    ) dut (
        .CLK      (clk),
        .RESET_IN (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.REQ_IN   = '0;
        bus.WRITE_IN = '0;
        bus.ACK_IN   = 1'b0;
        bus.DATA_IN  = '0;
        for (int i = 0; i < NP; i++) bus.ACS_IN[i] = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        #1;
        rst = 1'b0;
        tick();
    endtask

    // n acknowledged beats for the current owner; each beat checks ACK_OUT and read data.
    task automatic beats(input port_t port, input int n, input logic [15:0] dbase);
        for (int b = 0; b < n; b++) begin
            bus.ACK_IN            = 1'b1;
            bus.DATA_IN           = dbase + 16'(b);
            bus.ACS_IN[port].col  = 10'(b);
            #1;
            check("beat_ack", 32'(bus.ACK_OUT), 32'(4'b0001 << port));
            check("beat_rdata", 32'(bus.DATA_OUT[port]), 32'(dbase + 16'(b)));
            tick();
        end
        bus.ACK_IN = 1'b0;
    endtask

    // Continuous requesters; the finishing port drops REQ for the single idle cycle.
    task automatic rotate(input port_t ord [5], input int n);
        tick();
        for (int k = 0; k < n; k++) begin
            #1;
            check("rot_grant", 32'(bus.GRANT_OUT), 32'(4'b0001 << ord[k]));
            beats(ord[k], BL, 16'(16'h1000 * (k + 1)));
            bus.REQ_IN[ord[k]] = 1'b0;
            #1;
            check("rot_idle_grant", 32'(bus.GRANT_OUT), 32'h0);
            check("rot_idle_req", 32'(bus.REQ_OUT), 32'h0);
            tick();
            bus.REQ_IN[ord[k]] = 1'b1;
        end
    endtask

    initial begin
        // 1: reset holds outputs low despite requests, first pick is port 0
        clear_inputs();
        bus.REQ_IN   = 4'b1111;
        bus.WRITE_IN = 4'b1111;
        bus.ACK_IN   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            check("rst_req_out", 32'(bus.REQ_OUT), 32'h0);
            check("rst_grant", 32'(bus.GRANT_OUT), 32'h0);
        end
        check("rst_ack_out", 32'(bus.ACK_OUT), 32'h0);
        check("rst_write_out", 32'(bus.WRITE_OUT), 32'h0);
        check("rst_acs_out", 32'(bus.ACS_OUT), 32'h0);
        rst = 1'b0;
        #1;
        check("rel_grant_pre", 32'(bus.GRANT_OUT), 32'h0);
        tick();
        #1;
        check("rel_grant", 32'(bus.GRANT_OUT), 32'h1);
        check("rel_req_out", 32'(bus.REQ_OUT), 32'h1);
        check("rel_ack_fwd", 32'(bus.ACK_OUT), 32'h1);
        // asynchronous reset mid-burst drops outputs without waiting for an edge
        #1;
        rst = 1'b1;
        #1;
        check("arst_req_out", 32'(bus.REQ_OUT), 32'h0);
        check("arst_grant", 32'(bus.GRANT_OUT), 32'h0);
        check("arst_ack_out", 32'(bus.ACK_OUT), 32'h0);
        reset_dut();

        // 2: single read burst on port 2
        bus.ACS_IN[2].row  = 13'h12;
        bus.ACS_IN[2].bank = 2'd1;
        bus.REQ_IN         = 4'b0100;
        #1;
        check("rd_req_latency", 32'(bus.REQ_OUT), 32'h0);
        tick();
        #1;
        check("rd_grant", 32'(bus.GRANT_OUT), 32'h4);
        check("rd_req_out", 32'(bus.REQ_OUT), 32'h1);
        check("rd_row", 32'(bus.ACS_OUT.row), 32'h12);
        check("rd_bank", 32'(bus.ACS_OUT.bank), 32'h1);
        check("rd_write_out", 32'(bus.WRITE_OUT), 32'h0);
        beats(2'd2, BL, 16'hA000);
        bus.REQ_IN = '0;
        #1;
        check("rd_done_grant", 32'(bus.GRANT_OUT), 32'h0);
        check("rd_done_req", 32'(bus.REQ_OUT), 32'h0);

        // 3: fairness with all four ports requesting
        reset_dut();
        bus.REQ_IN = 4'b1111;
        rotate(ord_fair, 5);

        // 4: port 1 aborts after 3 beats, stray ACK ignored, port 2 follows
        reset_dut();
        bus.REQ_IN = 4'b0110;
        tick();
        #1;
        check("ab_grant1", 32'(bus.GRANT_OUT), 32'h2);
        beats(2'd1, 3, 16'hB000);
        bus.REQ_IN[1] = 1'b0;
        bus.ACK_IN    = 1'b1;
        #1;
        check("ab_req_drop", 32'(bus.REQ_OUT), 32'h0);
        check("ab_ack_ignored", 32'(bus.ACK_OUT), 32'h0);
        tick();
        #1;
        check("ab_idle_grant", 32'(bus.GRANT_OUT), 32'h0);
        check("ab_idle_ack", 32'(bus.ACK_OUT), 32'h0);
        bus.ACK_IN = 1'b0;
        tick();
        #1;
        check("ab_grant2", 32'(bus.GRANT_OUT), 32'h4);
        check("ab_req2", 32'(bus.REQ_OUT), 32'h1);
        beats(2'd2, BL, 16'hC000);
        bus.REQ_IN = '0;
        #1;
        check("ab_full_after", 32'(bus.GRANT_OUT), 32'h0);

        // 5: write burst on port 3 while other ports scribble on their inputs
        reset_dut();
        bus.REQ_IN   = 4'b1000;
        bus.WRITE_IN = 4'b1000;
        tick();
        for (int b = 0; b < BL; b++) begin
            bus.ACS_IN[3].col  = 10'(b);
            bus.ACS_IN[3].data = 16'h5A00 + 16'(b * 17);
            bus.ACS_IN[0].data = 16'hDEAD;
            bus.ACS_IN[1].row  = 13'(b + 100);
            bus.WRITE_IN[1]    = b[0];
            bus.ACK_IN         = 1'b1;
            #1;
            check("wr_write_out", 32'(bus.WRITE_OUT), 32'h1);
            check("wr_data", 32'(bus.ACS_OUT.data), 32'(16'h5A00 + 16'(b * 17)));
            check("wr_col", 32'(bus.ACS_OUT.col), 32'(b));
            check("wr_ack", 32'(bus.ACK_OUT), 32'h8);
            tick();
        end
        bus.ACK_IN = 1'b0;
        bus.REQ_IN = '0;
        #1;
        check("wr_done_grant", 32'(bus.GRANT_OUT), 32'h0);
        check("wr_done_write", 32'(bus.WRITE_OUT), 32'h0);

        // 6: ports 0 and 1 requesting repeatedly alternate
        reset_dut();
        bus.REQ_IN = 4'b0011;
        rotate(ord_pair, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
